// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Shares one synchronous memory port between the CPU (fixed
//           priority) and a secondary DMA / loader master with burst release.
//           Optional macro MEM_BUS_ARBITER_STARVE_GUARD_EN adds a forced grant
//           after STARVE_LIMIT consecutive denied DMA cycles.
// Revision: 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int BURST_MAX    = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic                  cpu_byt,
  input  logic [15:0]           cpu_wr_data,
  output logic [15:0]           cpu_rd_data,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  input  logic                  dma_lock,
  input  logic                  dma_we,
  input  logic                  dma_byt,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [15:0]           dma_wr_data,
  output logic                  dma_gnt,
  output logic                  dma_rd_valid,
  output logic [15:0]           dma_rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  mem_byt,
  output logic [15:0]           mem_wr_data,
  input  logic [15:0]           mem_rd_data
);

  typedef enum logic [0:0] {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam logic [7:0] C_BURST_MAX = 8'(BURST_MAX);
  localparam logic [7:0] C_CNT_MAX   = 8'hFF;

  if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_bad_burst_max
    $error("mem_bus_arbiter: BURST_MAX must be in 1..255");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("mem_bus_arbiter: STARVE_LIMIT must be in 1..255");
  end

  owner_t     r_owner;
  owner_t     w_owner_nxt;
  logic [7:0] r_burst_cnt;
  logic [7:0] w_burst_cnt_nxt;
  logic       r_rd_dma_d;
  logic       w_starve_force;
  logic       w_hold_dma;
  logic       w_gnt_dma;

`ifdef MEM_BUS_ARBITER_STARVE_GUARD_EN
  localparam logic [7:0] C_STARVE_LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] r_wait_cnt;
  // A forced grant steals a single cycle; it must not open a burst window.
  logic       r_forced;

  assign w_starve_force = (r_wait_cnt >= C_STARVE_LIMIT);
  assign w_hold_dma     = (r_owner == OWN_DMA) & !r_forced &
                          (dma_lock | (r_burst_cnt < C_BURST_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_forced   <= 1'b0;
    end else begin
      if (dma_req & !w_gnt_dma) begin
        r_wait_cnt <= (r_wait_cnt == C_CNT_MAX) ? C_CNT_MAX : r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= '0;
      end
      r_forced <= dma_req & cpu_req & w_starve_force & !w_hold_dma;
    end
  end
`else
  assign w_starve_force = 1'b0;
  assign w_hold_dma     = (r_owner == OWN_DMA) &
                          (dma_lock | (r_burst_cnt < C_BURST_MAX));
`endif

  assign w_gnt_dma = dma_req & (!cpu_req | w_hold_dma | w_starve_force);

  always_comb begin
    w_owner_nxt     = OWN_CPU;
    w_burst_cnt_nxt = '0;
    if (w_gnt_dma) begin
      w_owner_nxt     = OWN_DMA;
      w_burst_cnt_nxt = (r_burst_cnt == C_CNT_MAX) ? C_CNT_MAX : r_burst_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_CPU;
      r_burst_cnt <= '0;
      r_rd_dma_d  <= 1'b0;
    end else begin
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_rd_dma_d  <= w_gnt_dma & !dma_we;
    end
  end

  // Strobes are gated by reset so nothing reaches memory while rst_n is low.
  always_comb begin
    mem_addr    = cpu_addr;
    mem_rd      = cpu_rd & cpu_req;
    mem_wr      = cpu_wr & cpu_req;
    mem_byt     = cpu_byt;
    mem_wr_data = cpu_wr_data;
    if (w_gnt_dma) begin
      mem_addr    = dma_addr;
      mem_rd      = !dma_we;
      mem_wr      = dma_we;
      mem_byt     = dma_byt;
      mem_wr_data = dma_wr_data;
    end
    if (!rst_n) begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
    end
  end

  assign dma_gnt      = w_gnt_dma & rst_n;
  assign cpu_stall    = cpu_req & dma_gnt;
  assign dma_rd_valid = r_rd_dma_d & rst_n;
  assign dma_rd_data  = mem_rd_data;
  assign cpu_rd_data  = mem_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Brief   : Directed self-checking bench for mem_bus_arbiter with a word
//           memory model and read-return scoreboards.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_rd, cpu_wr, cpu_byt;
  logic [11:0] cpu_addr;
  logic [15:0] cpu_wr_data;
  logic [15:0] cpu_rd_data;
  logic        cpu_stall;
  logic        dma_req, dma_lock, dma_we, dma_byt;
  logic [11:0] dma_addr;
  logic [15:0] dma_wr_data;
  logic        dma_gnt, dma_rd_valid;
  logic [15:0] dma_rd_data;
  logic [11:0] mem_addr;
  logic        mem_rd, mem_wr, mem_byt;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] q_dma[$];
  logic [15:0] q_cpu[$];

  logic [15:0] mem_arr [0:4095];
  bit          mem_vld [0:4095];

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_WIDTH  (12),
    .BURST_MAX   (8),
    .STARVE_LIMIT(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_byt     (cpu_byt),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rd_data (cpu_rd_data),
    .cpu_stall   (cpu_stall),
    .dma_req     (dma_req),
    .dma_lock    (dma_lock),
    .dma_we      (dma_we),
    .dma_byt     (dma_byt),
    .dma_addr    (dma_addr),
    .dma_wr_data (dma_wr_data),
    .dma_gnt     (dma_gnt),
    .dma_rd_valid(dma_rd_valid),
    .dma_rd_data (dma_rd_data),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_byt     (mem_byt),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  // Unwritten locations read back a fixed pattern: 0x100 -> 0xA5A5, 0x101 -> 0xA5A6, ...
  function automatic logic [15:0] model_rd(input logic [11:0] a);
    if (mem_vld[a]) return mem_arr[a];
    return 16'hA5A5 + {4'h0, a} - 16'h0100;
  endfunction

  always @(posedge clk) begin
    if (mem_wr) begin
      mem_arr[mem_addr] <= mem_wr_data;
      mem_vld[mem_addr] <= 1'b1;
    end
    if (mem_rd) mem_rd_data <= model_rd(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the masters, then check the grant, the mux and the read return.
  task automatic step(input logic c_req, input logic [11:0] c_addr, input logic c_rd,
                      input logic c_wr, input logic d_req, input logic d_lock,
                      input logic d_we, input logic [11:0] d_addr,
                      input logic [15:0] d_wd, input logic exp_gnt);
    @(posedge clk); #1;
    cpu_req = c_req; cpu_addr = c_addr; cpu_rd = c_rd; cpu_wr = c_wr;
    cpu_byt = 1'b0;  cpu_wr_data = 16'h1111;
    dma_req = d_req; dma_lock = d_lock; dma_we = d_we; dma_addr = d_addr;
    dma_byt = d_addr[0]; dma_wr_data = d_wd;
    #1;
    chk("dma_gnt",   dma_gnt,   exp_gnt);
    chk("cpu_stall", cpu_stall, c_req & exp_gnt);
    chk("mem_addr",  mem_addr,  exp_gnt ? d_addr : c_addr);
    chk("mem_rd",    mem_rd,    exp_gnt ? !d_we : (c_req & c_rd));
    chk("mem_wr",    mem_wr,    exp_gnt ? d_we : (c_req & c_wr));
    chk("mem_byt",   mem_byt,   exp_gnt ? d_addr[0] : 1'b0);
    if (exp_gnt) chk("mem_wr_data", mem_wr_data, d_wd);
    if (q_dma.size() != 0) begin
      chk("dma_rd_valid", dma_rd_valid, 1'b1);
      chk("dma_rd_data", dma_rd_data, q_dma.pop_front());
    end else begin
      chk("dma_rd_valid", dma_rd_valid, 1'b0);
    end
    if (q_cpu.size() != 0) chk("cpu_rd_data", cpu_rd_data, q_cpu.pop_front());
    if (exp_gnt && !d_we) q_dma.push_back(model_rd(d_addr));
    if (!exp_gnt && c_req && c_rd) q_cpu.push_back(model_rd(c_addr));
  endtask

  task automatic idle();
    step(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
  endtask

  initial begin
    int n;
    logic exp;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_byt = 1'b0;
    cpu_wr_data = '0;
    dma_req = 1'b1; dma_lock = 1'b0; dma_we = 1'b0; dma_byt = 1'b0;
    dma_addr = 12'h100; dma_wr_data = '0;

    // Reset: strobes gated even though the DMA is requesting an idle bus
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dma_gnt",      dma_gnt,      1'b0);
    chk("rst_cpu_stall",    cpu_stall,    1'b0);
    chk("rst_mem_rd",       mem_rd,       1'b0);
    chk("rst_mem_wr",       mem_wr,       1'b0);
    chk("rst_dma_rd_valid", dma_rd_valid, 1'b0);
    dma_req = 1'b0;
    rst_n   = 1'b1;

    // CPU alone reads 0x300
    for (int i = 0; i < 4; i++)
      step(1'b1, 12'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0, 1'b0);
    idle();

    // DMA reads 0x100..0x103 with the CPU idle
    for (int i = 0; i < 4; i++)
      step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h100 + 12'(i), 16'h0, 1'b1);
    idle();

    // Unlocked burst of 12 writes; CPU arrives at grant 3 and is served after grant 8
    n = 0;
    repeat (2) begin
      step(1'b0, 12'h310, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h200 + 12'(n), 16'hD000 + 16'(n), 1'b1);
      n++;
    end
    repeat (6) begin
      step(1'b1, 12'h310, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h200 + 12'(n), 16'hD000 + 16'(n), 1'b1);
      n++;
    end
    repeat (2)
      step(1'b1, 12'h310, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h200 + 12'(n), 16'hD000 + 16'(n), 1'b0);
    repeat (4) begin
      step(1'b0, 12'h310, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h200 + 12'(n), 16'hD000 + 16'(n), 1'b1);
      n++;
    end
    idle();
    for (int i = 0; i < 12; i++) chk("burst_mem", model_rd(12'h200 + 12'(i)), 16'hD000 + 16'(i));

    // Locked burst: all 12 grants contiguous, CPU stalled for grants 3..12
    n = 0;
    repeat (2) begin
      step(1'b0, 12'h310, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h240 + 12'(n), 16'hE000 + 16'(n), 1'b1);
      n++;
    end
    repeat (10) begin
      step(1'b1, 12'h310, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h240 + 12'(n), 16'hE000 + 16'(n), 1'b1);
      n++;
    end
    step(1'b1, 12'h310, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 16'h0, 1'b0);
    // Lock without a request does nothing
    step(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 16'h0, 1'b0);
    idle();
    for (int i = 0; i < 12; i++) chk("lock_mem", model_rd(12'h240 + 12'(i)), 16'hE000 + 16'(i));

    // Burst counter saturates: after 259 grants it must not look like 3
    repeat (259)
      step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h400, 16'h4444, 1'b1);
    step(1'b1, 12'h310, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h400, 16'h4444, 1'b0);
    idle();

    // Both masters requesting continuously
    for (int i = 0; i < 1000; i++) begin
`ifdef MEM_BUS_ARBITER_STARVE_GUARD_EN
      exp = (i >= 16) && (((i - 16) % 17) == 0);
`else
      exp = 1'b0;
`endif
      step(1'b1, 12'h310, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h120, 16'h0, exp);
    end
    idle();

    // Reset asserted during a DMA read burst at grant 3
    for (int i = 0; i < 3; i++)
      step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h100 + 12'(i), 16'h0, 1'b1);
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_rd = 1'b1; cpu_addr = 12'h310;
    #1;
    chk("mid_rst_dma_gnt",      dma_gnt,      1'b0);
    chk("mid_rst_mem_rd",       mem_rd,       1'b0);
    chk("mid_rst_dma_rd_valid", dma_rd_valid, 1'b0);
    chk("mid_rst_cpu_stall",    cpu_stall,    1'b0);
    q_dma.delete();
    q_cpu.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_dma_gnt",      dma_gnt,      1'b0);
    chk("post_rst_cpu_stall",    cpu_stall,    1'b0);
    chk("post_rst_mem_addr",     mem_addr,     12'h310);
    chk("post_rst_dma_rd_valid", dma_rd_valid, 1'b0);
    q_cpu.push_back(model_rd(12'h310));
    step(1'b1, 12'h310, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h103, 16'h0, 1'b0);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
